exibidor_sequencia: RTL and testbench

Parametrised LED sequence player for the memory-game datapath. On request, it plays memory entries 0..limite onto the LED outputs with programmable on/off times and two speed modes, then reports completion. It generalises the fixed 4-LED "mostra_leds" phase of the game: LED count, address width and timing are parameters, and the block adds a fast mode and an abort.

---
 rtl/exibidor_sequencia.sv | 135 +++++++++++++
 tb/tb_exibidor_sequencia.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/exibidor_sequencia.sv
// LED sequence player: shows memory words 0..limite on the LEDs with
// programmable lit/dark times, a fast mode, an abort and a completion pulse.
module exibidor_sequencia #(
   parameter int N_LEDS     = 4,
   parameter int ADDR_W     = 4,
   parameter int CNT_W      = 12,
   parameter int T_ON       = 500,
   parameter int T_OFF      = 250,
   parameter int T_ON_FAST  = 250,
   parameter int T_OFF_FAST = 125
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              iniciar,
   input  logic              abortar,
   input  logic [ADDR_W-1:0] limite,
   input  logic              rapido,
   output logic [ADDR_W-1:0] endereco,
   input  logic [N_LEDS-1:0] dado,
   output logic [N_LEDS-1:0] leds,
   output logic              mostrando,
   output logic              pronto,
   output logic [2:0]        db_estado
);

   localparam logic [2:0] OCIOSO  = 3'd0;
   localparam logic [2:0] CARREGA = 3'd1;
   localparam logic [2:0] ACESO   = 3'd2;
   localparam logic [2:0] APAGADO = 3'd3;
   localparam logic [2:0] FIM     = 3'd4;

   // The timer counts 0..duration-1, so compare against the last value
   localparam logic [CNT_W-1:0] ON_LAST       = CNT_W'(T_ON - 1);
   localparam logic [CNT_W-1:0] OFF_LAST      = CNT_W'(T_OFF - 1);
   localparam logic [CNT_W-1:0] ON_FAST_LAST  = CNT_W'(T_ON_FAST - 1);
   localparam logic [CNT_W-1:0] OFF_FAST_LAST = CNT_W'(T_OFF_FAST - 1);

   logic [2:0]        estado;
   logic [ADDR_W-1:0] limite_reg;
   logic              rapido_reg;
   logic [CNT_W-1:0]  timer;
   logic [CNT_W-1:0]  on_last;
   logic [CNT_W-1:0]  off_last;

   always_comb begin
      on_last  = rapido_reg ? ON_FAST_LAST : ON_LAST;
      off_last = rapido_reg ? OFF_FAST_LAST : OFF_LAST;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado     <= OCIOSO;
         endereco   <= '0;
         leds       <= '0;
         limite_reg <= '0;
         rapido_reg <= 1'b0;
         timer      <= '0;
      end else begin
         case (estado)
            OCIOSO: begin
               endereco <= '0;
               leds     <= '0;
               timer    <= '0;
               if (iniciar) begin
                  limite_reg <= limite;
                  rapido_reg <= rapido;
                  estado     <= CARREGA;
               end
            end
            CARREGA: begin
               if (abortar) begin
                  estado   <= OCIOSO;
                  leds     <= '0;
                  endereco <= '0;
                  timer    <= '0;
               end else begin
                  leds   <= dado;
                  timer  <= '0;
                  estado <= ACESO;
               end
            end
            ACESO: begin
               if (abortar) begin
                  estado   <= OCIOSO;
                  leds     <= '0;
                  endereco <= '0;
                  timer    <= '0;
               end else if (timer == on_last) begin
                  leds   <= '0;
                  timer  <= '0;
                  estado <= APAGADO;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            APAGADO: begin
               // The last entry goes to FIM before endereco can wrap
               if (abortar) begin
                  estado   <= OCIOSO;
                  leds     <= '0;
                  endereco <= '0;
                  timer    <= '0;
               end else if (timer == off_last) begin
                  timer <= '0;
                  if (endereco == limite_reg) begin
                     estado <= FIM;
                  end else begin
                     endereco <= endereco + 1'b1;
                     estado   <= CARREGA;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            FIM: begin
               estado   <= OCIOSO;
               leds     <= '0;
               endereco <= '0;
               timer    <= '0;
            end
            default: begin
               estado   <= OCIOSO;
               leds     <= '0;
               endereco <= '0;
               timer    <= '0;
            end
         endcase
      end
   end

   assign mostrando = (estado == CARREGA) || (estado == ACESO) || (estado == APAGADO);
   assign pronto    = (estado == FIM);
   assign db_estado = estado;

endmodule

// File: tb/tb_exibidor_sequencia.sv
// Self-checking bench for exibidor_sequencia: directed and random sequences
// compared cycle by cycle against a timeline model of the playback.
module tb_exibidor_sequencia;

   logic       clock;
   logic       reset;
   logic       iniciar;
   logic       abortar;
   logic [3:0] limite;
   logic       rapido;
   logic [3:0] endereco;
   logic [3:0] dado;
   logic [3:0] leds;
   logic       mostrando;
   logic       pronto;
   logic [2:0] db_estado;

   logic [3:0] rom [16];
   int         total;
   int         bad;

   exibidor_sequencia #(
      .N_LEDS(4), .ADDR_W(4), .CNT_W(12),
      .T_ON(4), .T_OFF(2), .T_ON_FAST(2), .T_OFF_FAST(1)
   ) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .abortar(abortar),
      .limite(limite), .rapido(rapido), .endereco(endereco), .dado(dado),
      .leds(leds), .mostrando(mostrando), .pronto(pronto), .db_estado(db_estado)
   );

   assign dado = rom[endereco];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
         $error("[TB] check %s", tag);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, ".leds"}, 32'(leds), 0);
      checkOutput({tag, ".endereco"}, 32'(endereco), 0);
      checkOutput({tag, ".mostrando"}, 32'(mostrando), 0);
      checkOutput({tag, ".pronto"}, 32'(pronto), 0);
      checkOutput({tag, ".estado"}, 32'(db_estado), 0);
   endtask

   // act_type: 0 none, 1 abort at cycle act_k, 2 async reset at act_k,
   // 3 abortar together with iniciar in idle. Called at a negedge in idle.
   task automatic applyStimulus(input int lim, input int rap, input int hold, input int act_k, input int act_type);
      int ton, toff, per, last, e, p;
      ton  = rap ? 2 : 4;
      toff = rap ? 1 : 2;
      per  = 1 + ton + toff;
      last = (lim + 1) * per;
      iniciar = 1'b1;
      limite  = 4'(lim);
      rapido  = 1'(rap);
      abortar = (act_type == 3);
      @(negedge clock);
      abortar = 1'b0;
      for (int k = 0; k <= last; k++) begin
         if (k < last) begin
            e = k / per;
            p = k % per;
            checkOutput("endereco", 32'(endereco), e);
            checkOutput("leds", 32'(leds), (p >= 1 && p <= ton) ? 32'(rom[e]) : 0);
            checkOutput("estado", 32'(db_estado), (p == 0) ? 1 : ((p <= ton) ? 2 : 3));
            checkOutput("mostrando", 32'(mostrando), 1);
            checkOutput("pronto", 32'(pronto), 0);
         end else begin
            checkOutput("fim.endereco", 32'(endereco), lim);
            checkOutput("fim.leds", 32'(leds), 0);
            checkOutput("fim.estado", 32'(db_estado), 4);
            checkOutput("fim.mostrando", 32'(mostrando), 0);
            checkOutput("fim.pronto", 32'(pronto), 1);
         end
         iniciar = (hold != 0);
         if (k < last) begin
            limite = 4'($urandom);
            rapido = 1'($urandom);
         end else begin
            limite = 4'(lim);
            rapido = 1'(rap);
         end
         if (k == act_k && act_type == 1) begin
            abortar = 1'b1;
            @(negedge clock);
            abortar = 1'b0;
            checkIdle("abort");
            return;
         end
         if (k == act_k && act_type == 2) begin
            #2 reset = 1'b0;
            #1 checkIdle("async_reset");
            #1 reset = 1'b1;
            @(negedge clock);
            checkIdle("after_reset");
            return;
         end
         @(negedge clock);
      end
      checkIdle("idle_after");
   endtask

   initial begin
      int lim, rap, act, per, k;
      total   = 0;
      bad     = 0;
      reset   = 1'b0;
      iniciar = 1'b0;
      abortar = 1'b0;
      limite  = '0;
      rapido  = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));

      @(negedge clock);
      checkIdle("reset");
      reset = 1'b1;
      @(negedge clock);
      checkIdle("idle");

      $display("[TB] normal and fast playback");
      applyStimulus(3, 0, 0, -1, 0);
      applyStimulus(3, 1, 0, -1, 0);

      $display("[TB] single entry, iniciar held, abortar ignored in idle");
      applyStimulus(0, 0, 1, -1, 0);
      applyStimulus(0, 0, 0, -1, 3);

      $display("[TB] abort in second ACESO, async reset in APAGADO");
      applyStimulus(3, 0, 0, 7 + 2, 1);
      applyStimulus(3, 0, 0, -1, 0);
      applyStimulus(3, 0, 0, 7 + 5, 2);

      $display("[TB] full depth and zero words");
      for (int i = 0; i < 16; i++) rom[i] = 4'(i);
      applyStimulus(15, 0, 0, -1, 0);

      $display("[TB] random sequences");
      for (int n = 0; n < 14; n++) begin
         for (int i = 0; i < 16; i++) rom[i] = 4'($urandom);
         lim = $urandom_range(0, 6);
         rap = $urandom_range(0, 1);
         per = rap ? 4 : 7;
         act = $urandom_range(0, 3);
         k   = $urandom_range(1, (lim + 1) * per);
         applyStimulus(lim, rap, 0, k, act);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
